// File: rtl/mem_access_unit.sv
// Data-memory initiator: turns execute-stage load/store requests into memory pin activity
// and returns load beats (1-4 consecutive words) to writeback.
// Latency: a store occupies one cycle on the pins. A load's first beat appears on resp_valid
// at the second edge, counting the acceptance edge as the first. Each later beat takes two
// more edges at best.
// Backpressure: req_ready is high only when idle. resp_ready low parks the unit in RESP with
// the beat held stable and no memory traffic. At most one request is in flight.
//
// Ports:
//   clk, reset                     system clock; synchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_write, req_addr,           request payload: store flag, start word address,
//   req_wdata, req_len             store data, and load beats-1
//   mem_address, mem_wdata,        registered memory pins; the memory samples writes on
//   mem_write, mem_read            posedge and returns read data on negedge
//   mem_rdata                      read data, valid at the posedge that closes a mem_read cycle
//   resp_valid/resp_ready          load-beat handshake
//   resp_data, resp_last           beat payload; resp_last marks the final beat
//   busy                           unit is not idle
module mem_access_unit #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_last,
  input  logic              resp_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] beats_left;

  // Both are decoded straight from the state register. This lets a held request be taken
  // on the first idle cycle.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      beats_left  <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_last   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_address <= req_addr;
            beats_left  <= req_len;
            if (req_write) begin
              mem_wdata <= req_wdata;
              mem_write <= 1'b1;
              state     <= WR;
            end else begin
              mem_read  <= 1'b1;
              state     <= RD;
            end
          end
        end

        // The memory commits the store on the edge that closes this cycle.
        WR: begin
          mem_write <= 1'b0;
          state     <= IDLE;
        end

        // The memory captured read data on the negedge inside this cycle.
        RD: begin
          resp_data  <= mem_rdata;
          resp_valid <= 1'b1;
          resp_last  <= (beats_left == '0);
          mem_read   <= 1'b0;
          state      <= RESP;
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            if (beats_left == '0) begin
              resp_last <= 1'b0;
              state     <= IDLE;
            end else begin
              // The address wraps modulo 2^ADDR_W. The memory only decodes the low bits.
              beats_left  <= beats_left - LEN_W'(1);
              mem_address <= mem_address + ADDR_W'(1);
              mem_read    <= 1'b1;
              state       <= RD;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit, with a 256-word memory model behind the pins.
// Latency: checks are made 1 time unit after each posedge.
// Backpressure: resp_ready is driven explicitly per beat to exercise stalls.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_len;
  logic [63:0] mem_address;
  logic [63:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] mem_rdata;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_last;
  logic        resp_ready;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt = 0;
  logic preload = 1'b1;

  logic [63:0] mem [256];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_len     (req_len),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .mem_rdata   (mem_rdata),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_last   (resp_last),
    .resp_ready  (resp_ready),
    .busy        (busy)
  );

  // Memory model: writes on posedge, read data registered on negedge.
  // The memory is preloaded with known contents on the first edge.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 64'd0;
      mem[254] <= 64'd1;
      mem[255] <= 64'd2;
      mem[0]   <= 64'd3;
      mem[1]   <= 64'd4;
      mem[20]  <= 64'h100;
      mem[21]  <= 64'h101;
      mem[22]  <= 64'h102;
      mem[23]  <= 64'h103;
    end else if (mem_write) begin
      mem[mem_address[7:0]] <= mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (mem_read) mem_rdata <= mem[mem_address[7:0]];
  end

  always @(posedge clk) begin
    if (mem_read) rd_cnt <= rd_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue a load and walk every beat. exp_base+k is the hand-computed data for beat k.
  // stall_beat selects which beat (if any) is held for stall_cyc extra cycles.
  task automatic run_burst(input logic [63:0] addr, input int len, input logic [63:0] exp_base,
                           input int stall_beat, input int stall_cyc);
    logic [1:0] l;
    l = len[1:0];
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = addr;
    req_len    = l;
    resp_ready = 1'b0;
    tick;
    req_valid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      check_val("rd_strobe", mem_read, 1'b1);
      check_val("rd_addr", mem_address, addr + 64'(k));
      tick;
      check_val("beat_valid", resp_valid, 1'b1);
      check_val("beat_data", resp_data, exp_base + 64'(k));
      check_val("beat_last", resp_last, (k == len));
      check_val("rd_drop", mem_read, 1'b0);
      if (k == stall_beat) begin
        for (int s = 0; s < stall_cyc; s++) begin
          tick;
          check_val("stall_valid", resp_valid, 1'b1);
          check_val("stall_data", resp_data, exp_base + 64'(k));
          check_val("stall_noread", mem_read, 1'b0);
        end
      end
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
    end
    check_val("end_valid", resp_valid, 1'b0);
    check_val("end_last", resp_last, 1'b0);
    check_val("end_ready", req_ready, 1'b1);
  endtask

  initial begin
    int rd_snap;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_len    = '0;
    resp_ready = 1'b0;

    // Reset is held for two cycles.
    tick;
    preload = 1'b0;
    tick;
    check_val("rst_addr", mem_address, 64'd0);
    check_val("rst_wdata", mem_wdata, 64'd0);
    check_val("rst_write", mem_write, 1'b0);
    check_val("rst_read", mem_read, 1'b0);
    check_val("rst_rvalid", resp_valid, 1'b0);
    check_val("rst_rdata", resp_data, 64'd0);
    check_val("rst_rlast", resp_last, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_ready", req_ready, 1'b1);
    reset = 1'b0;

    // Store to address 5, then load it back.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'd5;
    req_wdata = 64'hAA;
    tick;
    req_valid = 1'b0;
    check_val("st_write", mem_write, 1'b1);
    check_val("st_addr", mem_address, 64'd5);
    check_val("st_wdata", mem_wdata, 64'hAA);
    check_val("st_busy", busy, 1'b1);
    check_val("st_notready", req_ready, 1'b0);
    tick;
    check_val("st_pulse_end", mem_write, 1'b0);
    check_val("st_idle", req_ready, 1'b1);
    check_val("st_no_resp", resp_valid, 1'b0);
    run_burst(64'd5, 0, 64'hAA, -1, 0);

    // Four-beat burst that crosses the 255->0 index wrap.
    run_burst(64'd254, 3, 64'd1, -1, 0);

    // Four-beat burst with beat 2 stalled for three cycles.
    run_burst(64'd20, 3, 64'h100, 1, 3);

    // Request held during a burst: it is not taken until the unit is idle again.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 64'd20;
    req_len   = 2'd1;
    tick;
    req_write = 1'b1;
    req_addr  = 64'd30;
    req_wdata = 64'h55;
    check_val("hold_notready", req_ready, 1'b0);
    tick;
    check_val("hold_nowrite1", mem_write, 1'b0);
    check_val("hold_beat1", resp_data, 64'h100);
    resp_ready = 1'b1;
    tick;
    check_val("hold_nowrite2", mem_write, 1'b0);
    check_val("hold_rd2", mem_address, 64'd21);
    check_val("hold_notready2", req_ready, 1'b0);
    tick;
    check_val("hold_beat2", resp_data, 64'h101);
    check_val("hold_last2", resp_last, 1'b1);
    tick;
    resp_ready = 1'b0;
    check_val("hold_idle", busy, 1'b0);
    check_val("hold_idle_valid", resp_valid, 1'b0);
    tick;
    req_valid = 1'b0;
    check_val("hold_accept_wr", mem_write, 1'b1);
    check_val("hold_accept_addr", mem_address, 64'd30);
    check_val("hold_accept_data", mem_wdata, 64'h55);
    tick;
    run_burst(64'd30, 0, 64'h55, -1, 0);

    // Reset while beat 2 of a four-beat burst waits in RESP.
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 64'd20;
    req_len    = 2'd3;
    resp_ready = 1'b0;
    tick;
    req_valid = 1'b0;
    tick;
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    tick;
    check_val("abort_pre_valid", resp_valid, 1'b1);
    check_val("abort_pre_data", resp_data, 64'h101);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_valid", resp_valid, 1'b0);
    check_val("abort_read", mem_read, 1'b0);
    check_val("abort_ready", req_ready, 1'b1);
    check_val("abort_addr", mem_address, 64'd0);
    rd_snap = rd_cnt;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    resp_ready = 1'b0;
    check_val("abort_no_reads", 64'(rd_cnt), 64'(rd_snap));
    check_val("abort_still_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
